dual_port_tcm: RTL and testbench

DUAL_PORT_TCM -- requirements
Module: dual_port_tcm

---
 rtl/dual_port_tcm_pkg.sv | 18 +
 rtl/dual_port_tcm_ram.sv | 36 +++
 rtl/dual_port_tcm.sv | 120 ++++++++++++
 tb/tb_dual_port_tcm.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dual_port_tcm_pkg.sv
// rtl/dual_port_tcm_pkg.sv - shared defaults and types for the dual-port TCM
package dual_port_tcm_pkg;

  localparam int DEF_AW         = 10;
  localparam int DEF_DW         = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int CNT_W          = 4;

  // Which requester owns the single RAM port this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_LS   = 2'd2
  } src_e;

  typedef logic [CNT_W-1:0] starve_cnt_t;

endpackage

// File: rtl/dual_port_tcm_ram.sv
// rtl/dual_port_tcm_ram.sv - single-port synchronous RAM with byte-enable write
module tcm_ram #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int NB = DW / 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [NB-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Byte-lane write on the accepting edge; contents are never reset
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read; the output only moves on a read access
  always_ff @(posedge clk) begin
    if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dual_port_tcm.sv
// rtl/dual_port_tcm.sv - fetch and load/store ports sharing one single-port RAM
module dual_port_tcm
  import dual_port_tcm_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  localparam int NB        = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [NB-1:0] ls_be,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata
);

  localparam starve_cnt_t STARVE_LIM = starve_cnt_t'(STARVE_MAX);

  starve_cnt_t   starve_cnt;
  logic          starve_force;
  src_e          src;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;

  logic          ls_rd_q;
  logic [DW-1:0] if_hold;
  logic [DW-1:0] ls_hold;

  // Arbitration: LS wins by default, a starved fetch forces its way in.
  // Grants look only at the request lines, counter and reset.
  always_comb begin
    src          = SRC_NONE;
    starve_force = if_req && (starve_cnt == STARVE_LIM);
    if (!rst) begin
      if (if_req && (starve_force || !ls_req)) begin
        src = SRC_IF;
      end else if (ls_req) begin
        src = SRC_LS;
      end
    end
  end

  assign if_gnt = (src == SRC_IF);
  assign ls_gnt = (src == SRC_LS);

  assign ram_en   = if_gnt || ls_gnt;
  assign ram_we   = ls_gnt && ls_we;
  assign ram_addr = ls_gnt ? ls_addr : if_addr;

  tcm_ram #(
    .AW (AW),
    .DW (DW),
    .NB (NB)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ls_be),
    .addr  (ram_addr),
    .wdata (ls_wdata),
    .rdata (ram_rdata)
  );

  // Count consecutive denied fetch cycles, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + starve_cnt_t'(1);
    end
  end

  // Return-valid pulses one cycle after each accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rd_q   <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      ls_rvalid <= ls_gnt;
      ls_rd_q   <= ls_gnt && !ls_we;
    end
  end

  // Per-port copies of the last returned word so RDATA holds between returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_hold <= '0;
      ls_hold <= '0;
    end else begin
      if (if_rvalid) begin
        if_hold <= ram_rdata;
      end
      if (ls_rvalid && ls_rd_q) begin
        ls_hold <= ram_rdata;
      end
    end
  end

  // Store acks leave LS_RDATA untouched; only loads show fresh RAM data
  assign if_rdata = if_rvalid ? ram_rdata : if_hold;
  assign ls_rdata = (ls_rvalid && ls_rd_q) ? ram_rdata : ls_hold;

endmodule

// File: tb/tb_dual_port_tcm.sv
// tb/tb_dual_port_tcm.sv - directed self-checking bench for dual_port_tcm
module tb_dual_port_tcm;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [9:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;

  int checks;
  int failures;
  logic [31:0] last_ls;
  logic [31:0] last_if;

  dual_port_tcm #(
    .AW         (10),
    .DW         (32),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_be     (ls_be),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ls_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_wdata = d; ls_be = be;
    #1;
    check("ls_wr_gnt", ls_gnt, 1);
    @(posedge clk); #1;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0;
    check("ls_wr_ack", ls_rvalid, 1);
    check("ls_wr_rdata_hold", ls_rdata, last_ls);
  endtask

  task automatic ls_read(input logic [9:0] a, input logic [31:0] exp);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = a; ls_be = 4'h0;
    #1;
    check("ls_rd_gnt", ls_gnt, 1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    check("ls_rd_rvalid", ls_rvalid, 1);
    check("ls_rd_data", ls_rdata, exp);
    last_ls = exp;
  endtask

  task automatic if_read(input logic [9:0] a, input logic [31:0] exp);
    if_req = 1'b1; if_addr = a;
    #1;
    check("if_rd_gnt", if_gnt, 1);
    check("if_rd_ls_gnt", ls_gnt, 0);
    @(posedge clk); #1;
    if_req = 1'b0;
    check("if_rd_rvalid", if_rvalid, 1);
    check("if_rd_data", if_rdata, exp);
    last_if = exp;
  endtask

  initial begin
    checks = 0; failures = 0; last_ls = '0; last_if = '0;
    rst = 1'b1;
    if_req = 1'b1; if_addr = '0;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'h0; ls_addr = '0; ls_wdata = '0;

    // Reset state, with both requests asserted
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_ls_gnt", ls_gnt, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_ls_rvalid", ls_rvalid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_ls_rdata", ls_rdata, 0);
    if_req = 1'b0; ls_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;

    // Fetch-only read of a word written through LS
    ls_write(10'h010, 32'hDEADBEEF, 4'hF);
    if_read(10'h010, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("if_rvalid_one_pulse", if_rvalid, 0);
    check("if_rdata_hold", if_rdata, 32'hDEADBEEF);

    // Byte enables
    ls_write(10'h020, 32'h11223344, 4'hF);
    ls_write(10'h020, 32'hAABBCCDD, 4'b0101);
    ls_read(10'h020, 32'h11BB33DD);

    // Read directly after write, consecutive cycles
    ls_write(10'h005, 32'hCAFEF00D, 4'hF);
    ls_read(10'h005, 32'hCAFEF00D);

    // Zero-strobe write: acked, memory unchanged
    ls_write(10'h030, 32'h55AA55AA, 4'hF);
    ls_write(10'h030, 32'hFFFFFFFF, 4'h0);
    ls_read(10'h030, 32'h55AA55AA);
    @(posedge clk); #1;
    check("ls_rvalid_one_pulse", ls_rvalid, 0);
    check("ls_rdata_hold", ls_rdata, 32'h55AA55AA);

    // Starvation: both held, expect LS x4 then IF, repeating
    if_req = 1'b1; if_addr = 10'h010;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h020;
    for (int c = 0; c < 10; c++) begin
      logic exp_if;
      exp_if = ((c % 5) == 4);
      #1;
      check($sformatf("starve_if_gnt_%0d", c), if_gnt, exp_if);
      check($sformatf("starve_ls_gnt_%0d", c), ls_gnt, !exp_if);
      @(posedge clk); #1;
      check($sformatf("starve_if_rvalid_%0d", c), if_rvalid, exp_if);
      check($sformatf("starve_ls_rvalid_%0d", c), ls_rvalid, !exp_if);
      if (exp_if) check($sformatf("starve_if_data_%0d", c), if_rdata, 32'hDEADBEEF);
      else        check($sformatf("starve_ls_data_%0d", c), ls_rdata, 32'h11BB33DD);
    end
    if_req = 1'b0; ls_req = 1'b0;
    last_ls = 32'h11BB33DD;
    @(posedge clk); #1;

    // Reset right after a fetch is accepted
    if_req = 1'b1; if_addr = 10'h020;
    #1;
    check("rstmid_if_gnt", if_gnt, 1);
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b0;
    #1;
    check("rstmid_if_rvalid", if_rvalid, 0);
    check("rstmid_if_rdata", if_rdata, 0);
    check("rstmid_ls_rdata", ls_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_ls = '0; last_if = '0;
    #1;
    check("post_rst_if_rvalid_a", if_rvalid, 0);
    @(posedge clk); #1;
    check("post_rst_if_rvalid_b", if_rvalid, 0);
    check("post_rst_if_rdata", if_rdata, 0);

    // Memory survives reset
    if_read(10'h020, 32'h11BB33DD);
    ls_read(10'h010, 32'hDEADBEEF);
    ls_read(10'h005, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
